// File: rtl/cpu_pkg.sv
// cpu_pkg: shared instruction width, bubble word and feeder FSM states
package cpu_pkg;
    localparam int INST_W = 32;
    localparam logic [INST_W-1:0] BUBBLE_INST = 32'h0;
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } feeder_state_e;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with wrap-bit pointers and occupancy count
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic push_ok, pop_ok;
    assign push_ok = i_push && !o_full;
    assign pop_ok  = i_pop && !o_empty;
    assign o_count = wr_ptr - rd_ptr;
    assign o_empty = wr_ptr == rd_ptr;
    assign o_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign o_data  = mem[rd_ptr[AW-1:0]];
    // pointers carry an extra wrap bit so full and empty are distinguishable
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
        end
    end
    // storage needs no reset; only entries between the pointers are ever read
    always_ff @(posedge i_clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= i_data;
    end
endmodule

// File: rtl/inst_feeder.sv
// inst_feeder: buffers loader words and issues one per cycle to the cpu core
module inst_feeder #(
    parameter int DEPTH = 16,
    parameter int TAIL_CYCLES = 10,
    parameter logic [cpu_pkg::INST_W-1:0] BUBBLE_INST = cpu_pkg::BUBBLE_INST
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_start,
    input  logic                        i_wr_valid,
    input  logic [cpu_pkg::INST_W-1:0]  i_wr_inst,
    input  logic                        i_wr_last,
    output logic                        o_wr_ready,
    input  logic                        i_cpu_stall,
    output logic [cpu_pkg::INST_W-1:0]  o_inst,
    output logic                        o_inst_valid,
    output logic [$clog2(DEPTH):0]      o_count,
    output logic                        o_done
);
    import cpu_pkg::*;
    localparam int TW = $clog2(TAIL_CYCLES + 1);
    feeder_state_e state, state_nxt;
    logic full, empty, push, pop, last_seen;
    logic [INST_W-1:0] head;
    logic [TW-1:0] tail;
    assign o_wr_ready = !full && !last_seen && (state == ST_IDLE || state == ST_RUN);
    assign push = i_wr_valid && o_wr_ready;
    assign pop  = state == ST_RUN && !i_cpu_stall && !empty;

    sync_fifo #(.WIDTH(INST_W), .DEPTH(DEPTH)) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (push),
        .i_data  (i_wr_inst),
        .i_pop   (pop),
        .o_data  (head),
        .o_full  (full),
        .o_empty (empty),
        .o_count (o_count)
    );

    // next state: popping the final buffered word of a complete program starts the tail
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  state_nxt = i_start ? ST_RUN : ST_IDLE;
            ST_RUN:   state_nxt = (pop && last_seen && o_count == ($clog2(DEPTH)+1)'(1)) ? ST_DRAIN : ST_RUN;
            ST_DRAIN: state_nxt = (tail == TW'(TAIL_CYCLES - 1)) ? ST_DONE : ST_DRAIN;
            ST_DONE:  state_nxt = i_start ? ST_DONE : ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // state, tail counter, end-of-program flag and registered done
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= ST_IDLE;
            tail      <= '0;
            last_seen <= 1'b0;
            o_done    <= 1'b0;
        end else begin
            state     <= state_nxt;
            tail      <= state == ST_DRAIN ? tail + 1'b1 : '0;
            last_seen <= (state == ST_DONE && state_nxt == ST_IDLE) ? 1'b0 : (last_seen || (push && i_wr_last));
            o_done    <= state == ST_DONE && state_nxt == ST_DONE;
        end
    end

    // output register: hold on stall in RUN, else issue the head or a bubble
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_inst       <= BUBBLE_INST;
            o_inst_valid <= 1'b0;
        end else if (!(state == ST_RUN && i_cpu_stall)) begin
            o_inst       <= pop ? head : BUBBLE_INST;
            o_inst_valid <= pop;
        end
    end
endmodule
